spi_adc_capture: RTL and testbench

SPI master front end for the RF power detector ADC. On a start pulse it runs one SPI mode-0 frame, sends the selected detector channel, and shifts in the 8-bit conversion result. It returns `adc_result` with a one-cycle `adc_eoc` strobe, which feeds the `ADC_RESULT`/`adc_eoc` inputs of the downstream RF power reader. It is the only block that drives the ADC's SPI pins.

---
 rtl/spi_adc_capture.sv | 193 +++++++++++++++++++
 tb/tb_spi_adc_capture.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_capture.sv
// SPI mode-0 master for the RF power detector ADC.
// One start pulse runs one frame: command {1, channel, 0000} plus zero padding
// goes out on mosi, and the 8-bit conversion result comes back on miso bits 7..0.
// The result is presented on adc_result together with a one-cycle adc_eoc strobe.
// Optional feature macro: SPI_ADC_PARITY_EN. It adds a 17th frame bit carrying
// odd parity over the result, and an adc_par_err output.
//
// state | meaning
// IDLE  | cs_n high, waiting for start
// SETUP | cs_n low, command MSB on mosi, sclk low for CLK_DIV cycles
// SHIFT | sclk toggles every CLK_DIV cycles, first toggle rises
// HOLD  | sclk low, cs_n low for CLK_DIV cycles after the last falling edge
// DONE  | cs_n high, result loaded, adc_eoc strobe
module spi_adc_capture #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] channel,
    output logic       busy,
    output logic [7:0] adc_result,
    output logic       adc_eoc,
`ifdef SPI_ADC_PARITY_EN
    output logic       adc_par_err,
`endif
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

`ifdef SPI_ADC_PARITY_EN
    localparam int unsigned NBITS = 17;
    localparam int unsigned RBITS = 9;
`else
    localparam int unsigned NBITS = 16;
    localparam int unsigned RBITS = 8;
`endif

    localparam logic [7:0] HC_LOAD  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(NBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         hc_q, hc_d;
    logic [4:0]         bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [NBITS-1:0]   cmd_q, cmd_d;
    logic               miso_s1_q, miso_s2_q;
    logic [2:0]         pipe_q, pipe_d;
    logic [RBITS-1:0]   shift_q, shift_d;
    logic [7:0]         result_q, result_d;
`ifdef SPI_ADC_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    // Next-state, sclk/mosi generation and miso capture.
    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cmd_d    = cmd_q;
        result_d = result_q;
        shift_d  = shift_q;
`ifdef SPI_ADC_PARITY_EN
        par_err_d = par_err_q;
`endif
        // pipe_q marks the rising edge travelling through the miso synchroniser,
        // so the bit is taken exactly when the synchronised copy is valid.
        pipe_d = {pipe_q[1:0], 1'b0};
        if (pipe_q[2]) begin
            shift_d = {shift_q[RBITS-2:0], miso_s2_q};
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start) begin
                    state_d = ST_SETUP;
                    hc_d    = HC_LOAD;
                    bit_d   = '0;
                    cmd_d   = {1'b1, channel, {(NBITS-4){1'b0}}};
                    mosi_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (hc_q == '0) begin
                    state_d = ST_SHIFT;
                    hc_d    = HC_LOAD;
                end else begin
                    hc_d = hc_q - 8'd1;
                end
            end
            ST_SHIFT: begin
                if (hc_q == '0) begin
                    hc_d   = HC_LOAD;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        pipe_d[0] = 1'b1;
                    end else begin
                        cmd_d  = {cmd_q[NBITS-2:0], 1'b0};
                        mosi_d = cmd_q[NBITS-2];
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    hc_d = hc_q - 8'd1;
                end
            end
            ST_HOLD: begin
                sclk_d = 1'b0;
                if (hc_q == '0) begin
                    // Load on entry to DONE so the result is valid alongside adc_eoc.
                    state_d  = ST_DONE;
                    result_d = shift_q[RBITS-1 -: 8];
`ifdef SPI_ADC_PARITY_EN
                    par_err_d = ~(^shift_q);
`endif
                end else begin
                    hc_d = hc_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, synchroniser and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            hc_q      <= '0;
            bit_q     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cmd_q     <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            pipe_q    <= '0;
            shift_q   <= '0;
            result_q  <= '0;
`ifdef SPI_ADC_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            bit_q     <= bit_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cmd_q     <= cmd_d;
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
            pipe_q    <= pipe_d;
            shift_q   <= shift_d;
            result_q  <= result_d;
`ifdef SPI_ADC_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign cs_n       = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign adc_eoc    = (state_q == ST_DONE);
    assign sclk       = sclk_q;
    assign mosi       = mosi_q;
    assign adc_result = result_q;
`ifdef SPI_ADC_PARITY_EN
    assign adc_par_err = par_err_q;
`endif

endmodule

// File: tb/tb_spi_adc_capture.sv
// Bench for spi_adc_capture: instance 0 at CLK_DIV=4, instance 1 at CLK_DIV=2.
// A sampled ADC model answers each frame with a chosen byte; frame timing,
// command word and result are predicted from the frame arithmetic.
module tb_spi_adc_capture;

`ifdef SPI_ADC_PARITY_EN
    localparam int NB = 17;
    localparam int FR = 36;
`else
    localparam int NB = 16;
    localparam int FR = 34;
`endif

    logic       clk;
    logic       rst;
    logic       start_s   [2];
    logic [2:0] channel_s [2];
    logic       busy_s    [2];
    logic [7:0] res_s     [2];
    logic       eoc_s     [2];
    logic       sclk_s    [2];
    logic       cs_n_s    [2];
    logic       mosi_s    [2];
    logic       miso_s    [2];
`ifdef SPI_ADC_PARITY_EN
    logic       par_s     [2];
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ADC model and monitor state
    logic [7:0]  adc_val   [2];
    logic        adc_par   [2];
    int          falls     [2];
    int          rises     [2];
    logic [31:0] mosi_cap  [2];
    logic        prev_sclk [2];
    logic        prev_csn  [2];
    logic        prev_eoc  [2];
    logic [7:0]  prev_res  [2];
    int          hi_run    [2];
    int          min_gap   [2];
    logic        seen      [2];
    int          eoc_cnt   [2];
    int          consec    [2];
    int          bad_res   [2];
    int          exp_eoc   [2];

    spi_adc_capture #(.CLK_DIV(4)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s[0]),
        .channel    (channel_s[0]),
        .busy       (busy_s[0]),
        .adc_result (res_s[0]),
        .adc_eoc    (eoc_s[0]),
`ifdef SPI_ADC_PARITY_EN
        .adc_par_err(par_s[0]),
`endif
        .sclk       (sclk_s[0]),
        .cs_n       (cs_n_s[0]),
        .mosi       (mosi_s[0]),
        .miso       (miso_s[0])
    );

    spi_adc_capture #(.CLK_DIV(2)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s[1]),
        .channel    (channel_s[1]),
        .busy       (busy_s[1]),
        .adc_result (res_s[1]),
        .adc_eoc    (eoc_s[1]),
`ifdef SPI_ADC_PARITY_EN
        .adc_par_err(par_s[1]),
`endif
        .sclk       (sclk_s[1]),
        .cs_n       (cs_n_s[1]),
        .mosi       (mosi_s[1]),
        .miso       (miso_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC drives result bits after falling edge f = 8..15 (parity after f = 16)
    function automatic logic bit_for(input int i, input int f);
        logic [7:0] v;
        v = adc_val[i];
        if (f >= 8 && f <= 15) return v[15-f];
`ifdef SPI_ADC_PARITY_EN
        if (f == 16) return adc_par[i];
`endif
        return 1'b0;
    endfunction

    // ADC model and bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            prev_sclk[i] <= sclk_s[i];
            prev_csn[i]  <= cs_n_s[i];
            prev_eoc[i]  <= eoc_s[i];
            prev_res[i]  <= res_s[i];
            if (cs_n_s[i]) hi_run[i] <= hi_run[i] + 1;
            if (prev_csn[i] && !cs_n_s[i]) begin
                falls[i]    <= 0;
                rises[i]    <= 0;
                mosi_cap[i] <= '0;
                miso_s[i]   <= 1'b0;
                hi_run[i]   <= 0;
                seen[i]     <= 1'b1;
                if (seen[i] && hi_run[i] < min_gap[i]) min_gap[i] <= hi_run[i];
            end else begin
                if (prev_sclk[i] && !sclk_s[i]) begin
                    falls[i]  <= falls[i] + 1;
                    miso_s[i] <= bit_for(i, falls[i] + 1);
                end
                if (!prev_sclk[i] && sclk_s[i]) begin
                    rises[i]    <= rises[i] + 1;
                    mosi_cap[i] <= {mosi_cap[i][30:0], mosi_s[i]};
                end
            end
            if (eoc_s[i]) begin
                eoc_cnt[i] <= eoc_cnt[i] + 1;
                if (prev_eoc[i]) consec[i] <= consec[i] + 1;
            end
            if (res_s[i] != prev_res[i] && !eoc_s[i]) bad_res[i] <= bad_res[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on instance idx; returns in the DONE cycle when spam is set
    task automatic run_frame(input int idx, input logic [2:0] ch, input logic [7:0] val,
                             input bit par_ok, input bit spam, input bit chg);
        int d, n, first_rise, eoc_edge, busy_bad;
        logic [31:0] exp_word;
        d = (idx == 0) ? 4 : 2;
        adc_val[idx] = val;
        adc_par[idx] = par_ok ? ~(^val) : (^val);
        @(negedge clk);
        channel_s[idx] = ch;
        start_s[idx]   = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        if (!spam) start_s[idx] = 1'b0;
        if (chg) channel_s[idx] = ~ch;
        chk("accept_busy_csn", {30'd0, busy_s[idx], cs_n_s[idx]}, 32'd2);
        first_rise = -1;
        eoc_edge   = -1;
        busy_bad   = 0;
        for (int k = 0; k < 40 * d + 10; k++) begin
            @(negedge clk);
            if (!busy_s[idx] || (cs_n_s[idx] && !eoc_s[idx])) busy_bad++;
            if (sclk_s[idx] && first_rise < 0) first_rise = cyc;
            if (eoc_s[idx]) begin
                eoc_edge = cyc;
                break;
            end
        end
        exp_word = 32'({1'b1, ch, 4'b0000}) << (NB - 8);
        chk("eoc_time", eoc_edge, n + FR * d);
        chk("first_rise", first_rise, n + 2 * d);
        chk("busy_window", busy_bad, 0);
        chk("result", {24'd0, res_s[idx]}, {24'd0, val});
        chk("mosi_word", mosi_cap[idx], exp_word);
        chk("sclk_rises", rises[idx], NB);
`ifdef SPI_ADC_PARITY_EN
        chk("par_err", {31'd0, par_s[idx]}, {31'd0, ~par_ok});
`endif
        exp_eoc[idx]++;
        if (!spam) begin
            @(negedge clk);
            chk("idle_after", {27'd0, busy_s[idx], cs_n_s[idx], eoc_s[idx], sclk_s[idx], mosi_s[idx]},
                32'b01000);
        end
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; channel_s[i] = 3'd0; miso_s[i] = 1'b0;
            adc_val[i] = 8'd0; adc_par[i] = 1'b0; falls[i] = 0; rises[i] = 0;
            mosi_cap[i] = '0; prev_sclk[i] = 1'b0; prev_csn[i] = 1'b1; prev_eoc[i] = 1'b0;
            prev_res[i] = 8'd0; hi_run[i] = 0; min_gap[i] = 1000; seen[i] = 1'b0;
            eoc_cnt[i] = 0; consec[i] = 0; bad_res[i] = 0; exp_eoc[i] = 0;
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs", {26'd0, busy_s[i], cs_n_s[i], eoc_s[i], sclk_s[i], mosi_s[i], 1'b0},
                32'b010000);
            chk("reset_result", {24'd0, res_s[i]}, 32'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // basic read and channel encoding with mid-frame channel changes
        run_frame(0, 3'd1, 8'd180, 1'b1, 1'b0, 1'b0);
        run_frame(0, 3'd7, 8'($urandom_range(255)), 1'b1, 1'b0, 1'b1);
        run_frame(0, 3'd0, 8'($urandom_range(255)), 1'b1, 1'b0, 1'b1);

        // start held high across the whole frame and DONE, then back-to-back
        run_frame(0, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'b1, 1'b1, 1'b0);
        run_frame(0, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);

        // zero result first, then abort a frame with reset during bit 5
        run_frame(0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0);
        adc_val[0] = 8'hA5;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        waited = 0;
        while (falls[0] < 5 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("reach_bit5", {31'd0, waited < 500}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {28'd0, busy_s[0], cs_n_s[0], eoc_s[0], sclk_s[0]}, 32'b0100);
        chk("rst_mid_result", {24'd0, res_s[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_eoc_after_abort", eoc_cnt[0], exp_eoc[0]);
        chk("idle_without_start", {31'd0, cs_n_s[0]}, 32'd1);
        run_frame(0, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);

        // CLK_DIV=2 boundaries plus random frames
        run_frame(1, 3'($urandom_range(7)), 8'hFF, 1'b1, 1'b0, 1'b0);
        run_frame(1, 3'($urandom_range(7)), 8'h00, 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            run_frame(1, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);
            run_frame(0, 3'($urandom_range(7)), 8'($urandom_range(255)), 1'b1, 1'b0, 1'b0);
        end

`ifdef SPI_ADC_PARITY_EN
        run_frame(0, 3'd3, 8'h03, 1'b1, 1'b0, 1'b0);
        run_frame(0, 3'd3, 8'h03, 1'b0, 1'b0, 1'b0);
        run_frame(1, 3'd5, 8'($urandom_range(255)), 1'b0, 1'b0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("eoc_count", eoc_cnt[i], exp_eoc[i]);
            chk("eoc_consecutive", consec[i], 0);
            chk("result_change_outside_done", bad_res[i], 0);
        end
        chk("csn_min_gap_b2b", min_gap[0], 2);
        chk("csn_min_gap_div2", {31'd0, min_gap[1] >= 2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
